key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 The module SHALL have parameter LONG_T, default 50_000_000, hold time in clk cycles that classifies a press as long (1 s at 50 MHz).
REQ-002 The module SHALL have parameter DBL_T, default 15_000_000, maximum release-to-second-press gap in clk cycles for a double click.
REQ-003 The module SHALL have parameter REP_T, default 10_000_000, auto-repeat period in clk cycles while a long press is held.
REQ-004 The module SHALL have port clk, input, 1 bit, the single system clock; all state is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-006 The module SHALL have port key_level, input, 1 bit, the debounced key level from key_filter key_out (1 = released, 0 = pressed).
REQ-007 The module SHALL have port short_press, output, 1 bit, a one-cycle pulse marking a single short click.
REQ-008 The module SHALL have port double_click, output, 1 bit, a one-cycle pulse marking a double click.
REQ-009 The module SHALL have port long_press, output, 1 bit, a one-cycle pulse when the hold reaches LONG_T.
REQ-010 The module SHALL have port repeat_pulse, output, 1 bit, a one-cycle pulse every REP_T cycles while a long press is held.
REQ-011 The module SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL register key_level into key_d: press_det = key_d & ~key_level, rel_det = ~key_d & key_level.
REQ-013 The block SHALL use a 32-bit counter cnt; LONG_T, DBL_T and REP_T SHALL each be >= 2 and < 2^32.
REQ-014 The FSM SHALL have exactly the states IDLE, PRESS1, WAIT2, PRESS2 and LONG.
REQ-015 In IDLE, press_det SHALL move the FSM to PRESS1 and clear cnt.
REQ-016 In PRESS1, rel_det SHALL move the FSM to WAIT2 and clear cnt.
REQ-017 In PRESS1 otherwise, when cnt == LONG_T-1 the FSM SHALL move to LONG, clear cnt and pulse long_press; in all other PRESS1 cycles cnt SHALL increment.
REQ-018 In WAIT2, press_det SHALL move the FSM to PRESS2 and pulse double_click.
REQ-019 In WAIT2 otherwise, when cnt == DBL_T-1 the FSM SHALL return to IDLE and pulse short_press; in all other WAIT2 cycles cnt SHALL increment.
REQ-020 In PRESS2, the FSM SHALL perform no long-press detection and SHALL return to IDLE on rel_det.
REQ-021 In LONG, rel_det SHALL return the FSM to IDLE with no pulse.
REQ-022 In LONG otherwise, when cnt == REP_T-1 the block SHALL pulse repeat_pulse and set cnt to 0; in all other LONG cycles cnt SHALL increment.
REQ-023 All outputs SHALL be registered; each pulse SHALL be high for exactly one cycle, the cycle after the deciding clock edge.
REQ-024 At most one of short_press, double_click, long_press and repeat_pulse SHALL be high in any cycle.
REQ-025 In PRESS1, if rel_det coincides with cnt == LONG_T-1, the release SHALL take priority: the FSM goes to WAIT2 and long_press is not pulsed.
REQ-026 In WAIT2, if press_det coincides with cnt == DBL_T-1, the press SHALL take priority: double_click is pulsed and short_press is not.
REQ-027 In LONG, if rel_det coincides with cnt == REP_T-1, the release SHALL take priority and repeat_pulse SHALL NOT be pulsed.
REQ-028 Event latency: long_press SHALL rise LONG_T cycles after the press_det edge; short_press SHALL rise DBL_T cycles after the rel_det edge; the first repeat_pulse SHALL rise REP_T cycles after long_press, with later repeats spaced REP_T cycles apart.

Reset
REQ-029 On rst_n low, immediately and asynchronously: FSM to IDLE, cnt = 0, key_d = 1, and all five outputs = 0.
REQ-030 After rst_n rises, a key already held low SHALL produce press_det on the first clock edge.
REQ-031 Reset asserted mid-sequence SHALL discard the pending event with no pulse emitted.

Verification (LONG_T=8, DBL_T=5, REP_T=4; key_level driven synchronously)
REQ-032 Single press: low 3 cycles then high -> short_press is one pulse, 5 cycles after the release edge; no other pulses.
REQ-033 Double click: low 3, high 2, low 3, high -> double_click is one pulse the cycle after the second press edge; no short_press.
REQ-034 Long hold: low 20 cycles -> long_press at press+8; repeat_pulse at press+12, +16, +20; no pulse after release.
REQ-035 Boundary: release exactly on the cycle cnt == 7 -> no long_press, and short_press follows 5 cycles later; second press exactly at WAIT2 cnt == 4 -> double_click only.
REQ-036 Reset: drop rst_n during LONG -> outputs 0 and busy 0 at once; key held low through reset release -> PRESS1 entered on the first edge.

Source files
------------

// File: rtl/key_event_ctrl.sv
// Key event classifier: turns a debounced key level into single-click, double-click,
// long-press and auto-repeat pulses, with a busy flag while a gesture is in progress.
module key_event_ctrl #(
  parameter int unsigned LONG_T = 50_000_000,
  parameter int unsigned DBL_T  = 15_000_000,
  parameter int unsigned REP_T  = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_level,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        key_dly_q;
  logic        short_q, double_q, long_q, repeat_q, busy_q;
  logic        short_d, double_d, long_d, repeat_d;

  // Key level is active-low, so a press is a 1->0 transition.
  logic press_det, rel_det;
  assign press_det = key_dly_q & ~key_level;
  assign rel_det   = ~key_dly_q & key_level;

  logic long_hit, dbl_hit, rep_hit;
  assign long_hit = (cnt_q == LONG_T - 1);
  assign dbl_hit  = (cnt_q == DBL_T - 1);
  assign rep_hit  = (cnt_q == REP_T - 1);

  // key_dly_q resets to 1 so a key already held at reset release is seen as a press.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_dly_q <= 1'b1;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_dly_q <= key_level;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Key edges always take priority over counter expiry in the same cycle.
  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (press_det) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (rel_det) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (long_hit) begin
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT2: begin
        if (press_det) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (dbl_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESS2: begin
        if (rel_det) begin
          state_d = IDLE;
        end
      end
      LONG: begin
        if (rel_det) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rep_hit) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse decisions mirror the transition priorities, so at most one fires per cycle.
  always_comb begin
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      PRESS1:  long_d   = ~rel_det & long_hit;
      WAIT2: begin
        double_d = press_det;
        short_d  = ~press_det & dbl_hit;
      end
      LONG:    repeat_d = ~rel_det & rep_hit;
      default: ;
    endcase
  end

  assign short_press  = short_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short timing constants (LONG_T=8, DBL_T=5, REP_T=4).
module tb_key_event_ctrl;

  logic clk;
  logic rst_n;
  logic key_level;
  logic short_press, double_click, long_press, repeat_pulse, busy;

  key_event_ctrl #(
    .LONG_T(8),
    .DBL_T (5),
    .REP_T (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_level   (key_level),
    .short_press (short_press),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-run pulse statistics; *_at holds the tick index of the first pulse (-1 if none).
  int sp_n, sp_at, dc_n, dc_at, lp_n, lp_at, rp_n, multi;
  int rp_at[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tick t drives key low when t is in [a0,a1) or [b0,b1); tick 0 is the first press edge.
  task automatic run(input int n, input int a0, input int a1, input int b0, input int b1);
    sp_n = 0; sp_at = -1; dc_n = 0; dc_at = -1;
    lp_n = 0; lp_at = -1; rp_n = 0; multi = 0;
    for (int i = 0; i < 4; i++) rp_at[i] = -1;
    for (int t = 0; t < n; t++) begin
      key_level = !((t >= a0 && t < a1) || (t >= b0 && t < b1));
      @(posedge clk);
      #1;
      if (short_press)  begin if (sp_n == 0) sp_at = t; sp_n++; end
      if (double_click) begin if (dc_n == 0) dc_at = t; dc_n++; end
      if (long_press)   begin if (lp_n == 0) lp_at = t; lp_n++; end
      if (repeat_pulse) begin if (rp_n < 4) rp_at[rp_n] = t; rp_n++; end
      if (int'(short_press) + int'(double_click) + int'(long_press) + int'(repeat_pulse) > 1)
        multi++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_level = 1'b1;
    #12;
    check("rst_short", short_press, 0);
    check("rst_double", double_click, 0);
    check("rst_long", long_press, 0);
    check("rst_repeat", repeat_pulse, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", busy, 0);

    // Single click: short_press 5 cycles after the release edge at tick 3.
    run(14, 0, 3, 0, 0);
    check("single_sp_n", sp_n, 1);
    check("single_sp_at", sp_at, 8);
    check("single_dc_n", dc_n, 0);
    check("single_lp_n", lp_n, 0);
    check("single_rp_n", rp_n, 0);
    check("single_busy_end", busy, 0);

    // Double click: second press edge at tick 5.
    run(16, 0, 3, 5, 8);
    check("double_dc_n", dc_n, 1);
    check("double_dc_at", dc_at, 5);
    check("double_sp_n", sp_n, 0);
    check("double_lp_n", lp_n, 0);
    check("double_busy_end", busy, 0);

    // Long hold, released at tick 21: long at 8, repeats at 12, 16, 20.
    run(26, 0, 21, 0, 0);
    check("long_lp_n", lp_n, 1);
    check("long_lp_at", lp_at, 8);
    check("long_rp_n", rp_n, 3);
    check("long_rp0", rp_at[0], 12);
    check("long_rp1", rp_at[1], 16);
    check("long_rp2", rp_at[2], 20);
    check("long_sp_n", sp_n, 0);
    check("long_dc_n", dc_n, 0);
    check("long_busy_end", busy, 0);

    // Release coincides with the repeat boundary at tick 16: no repeat there.
    run(22, 0, 16, 0, 0);
    check("lrel_lp_at", lp_at, 8);
    check("lrel_rp_n", rp_n, 1);
    check("lrel_rp0", rp_at[0], 12);
    check("lrel_sp_n", sp_n, 0);

    // Release exactly when PRESS1 cnt == 7: no long_press, short at 8+5.
    run(16, 0, 8, 0, 0);
    check("bnd_rel_lp_n", lp_n, 0);
    check("bnd_rel_sp_n", sp_n, 1);
    check("bnd_rel_sp_at", sp_at, 13);

    // Second press exactly when WAIT2 cnt == 4: double only.
    run(20, 0, 3, 8, 10);
    check("bnd_dbl_dc_n", dc_n, 1);
    check("bnd_dbl_dc_at", dc_at, 8);
    check("bnd_dbl_sp_n", sp_n, 0);
    check("bnd_dbl_busy_end", busy, 0);

    check("multi_hot", multi, 0);

    // Reset during LONG while long_press is high, key held through reset release.
    key_level = 1'b0;
    for (int t = 0; t < 9; t++) tick();
    check("mid_lp_pre", long_press, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_long", long_press, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_repeat", repeat_pulse, 0);
    tick();
    check("mid_rst_hold_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 1);
    check("post_rst_lp", long_press, 0);
    for (int t = 0; t < 7; t++) tick();
    check("post_rst_lp_early", long_press, 0);
    tick();
    check("post_rst_lp_on", long_press, 1);
    key_level = 1'b1;
    tick();
    tick();
    check("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
